intr_ctrl: RTL

Interrupt controller that sequences prioritised interrupt sources towards a single CPU interrupt line. It captures rising edges on N request lines into pending bits and applies a per-source enable mask. It arbitrates among eligible sources and runs an ack / end-of-interrupt (EOI) handshake. It sits between the peripheral request lines and the core, replacing a bare registered priority encoder with state that survives until the core services each event.

---
 rtl/intr_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - prioritised interrupt controller with pending capture, mask and ack/EOI handshake.
// Optional rotating priority enabled by defining INTR_CTRL_RR_EN.
module intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] req_i,
    input  logic             mask_we_i,
    input  logic [N_SRC-1:0] mask_i,
    input  logic             ack_i,
    input  logic             eoi_i,
    output logic             irq_o,
    output logic [VEC_W-1:0] vec_o,
    output logic             busy_o,
    output logic [N_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] req_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] eligible, events, clr;
    logic [VEC_W-1:0] vec_q, vec_d, win;
    logic             armed_q;
    logic             ack_take;

    // The first cycle after reset only primes the history, so lines already
    // high when reset releases do not fabricate an event.
    assign events    = armed_q ? (req_i & ~req_prev_q) : '0;
    assign eligible  = pending_q & mask_q;
    assign ack_take  = (state_q == REQ) && ack_i;
    assign clr       = ack_take ? (N_SRC'(1) << vec_q) : '0;
    assign pending_d = (pending_q & ~clr) | events;

`ifdef INTR_CTRL_RR_EN
    logic [VEC_W-1:0] lp_q;

    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = int'(lp_q) - i;
            if (idx < 0) idx = idx + N_SRC;
            if (!found && eligible[idx]) begin
                win   = VEC_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       lp_q <= '0;
        else if (ack_take) lp_q <= vec_q;
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i]) win = VEC_W'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    vec_d   = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_i)                 state_d = SERVICE;
                else if (!eligible[vec_q]) state_d = IDLE;
            end
            SERVICE: begin
                if (eoi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            req_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            req_prev_q <= req_i;
            pending_q  <= pending_d;
            armed_q    <= 1'b1;
            if (mask_we_i) mask_q <= mask_i;
        end
    end

    assign irq_o     = (state_q == REQ);
    assign busy_o    = (state_q == SERVICE);
    assign vec_o     = (state_q == IDLE) ? '0 : vec_q;
    assign pending_o = pending_q;

endmodule
